// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and requester-id encoding for the writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefAddrW = 5;
   localparam int unsigned DefNReg  = 32;

   // Requester ids; also the encoding of the round-robin pointer.
   typedef enum logic {
      SrcA = 1'b0,
      SrcB = 1'b1
   } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_rf_scoreboard.sv
// Per-register pending scoreboard with read-after-write hazard compare.
module regfile_wb_arbiter_rf_scoreboard
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned NREG   = DefNReg
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              iss_valid_i,
   input  logic [ADDR_W-1:0] iss_rd_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_rd_i,
   input  logic [ADDR_W-1:0] chk_rs1_i,
   input  logic [ADDR_W-1:0] chk_rs2_i,
   output logic              hazard_o,
   output logic [NREG-1:0]   pending_o
);

   logic [NREG-1:0] pending_d, pending_q;

   // Next pending vector: clear on writeback, then set on issue so a newer producer wins.
   always_comb begin
      pending_d = pending_q;
      if (wr_en_i) begin
         pending_d[wr_rd_i] = 1'b0;
      end
      if (iss_valid_i && (iss_rd_i != '0)) begin
         pending_d[iss_rd_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Pending register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // No bypass: a source stays hazardous until the edge after its write.
   always_comb begin
      hazard_o  = (pending_q[chk_rs1_i] && (chk_rs1_i != '0)) ||
                  (pending_q[chk_rs2_i] && (chk_rs2_i != '0));
      pending_o = pending_q;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// writeback, with a registered write stage and a pending-write scoreboard.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned NREG   = DefNReg
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              rf_regwrite,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   output logic              hazard,
   output logic [NREG-1:0]   pending
);

   src_e              last_d, last_q;
   logic              regwrite_d, regwrite_q;
   logic [ADDR_W-1:0] rd_d, rd_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;

   // Grant: sole requester wins; on a tie the one not granted last wins. Held off in reset.
   always_comb begin
      a_ready = reset && a_valid && (!b_valid || (last_q == SrcB));
      b_ready = reset && b_valid && (!a_valid || (last_q == SrcA));
   end

   // Next-state for pointer and write stage; rd/data hold when nothing transfers.
   always_comb begin
      last_d     = last_q;
      regwrite_d = 1'b0;
      rd_d       = rd_q;
      wdata_d    = wdata_q;
      if (a_ready) begin
         last_d     = SrcA;
         regwrite_d = (a_rd != '0);
         rd_d       = a_rd;
         wdata_d    = a_data;
      end else if (b_ready) begin
         last_d     = SrcB;
         regwrite_d = (b_rd != '0);
         rd_d       = b_rd;
         wdata_d    = b_data;
      end
   end

   // State registers; reset leaves last=B so A wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_q     <= SrcB;
         regwrite_q <= 1'b0;
         rd_q       <= '0;
         wdata_q    <= '0;
      end else begin
         last_q     <= last_d;
         regwrite_q <= regwrite_d;
         rd_q       <= rd_d;
         wdata_q    <= wdata_d;
      end
   end

   // Drive the register-file write port from the registered stage.
   always_comb begin
      rf_regwrite = regwrite_q;
      rf_rd       = rd_q;
      rf_wdata    = wdata_q;
   end

   regfile_wb_arbiter_rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
   ) u_scoreboard (
      .clk_i       (clk),
      .rst_ni      (reset),
      .iss_valid_i (iss_valid),
      .iss_rd_i    (iss_rd),
      .wr_en_i     (regwrite_q),
      .wr_rd_i     (rd_q),
      .chk_rs1_i   (chk_rs1),
      .chk_rs2_i   (chk_rs2),
      .hazard_o    (hazard),
      .pending_o   (pending)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention, alternation,
// register-0 handling and the pending scoreboard.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [4:0]  a_rd, b_rd, rf_rd, iss_rd, chk_rs1, chk_rs2;
   logic [15:0] a_data, b_data, rf_wdata;
   logic        rf_regwrite, iss_valid, hazard;
   logic [31:0] pending;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .a_valid     (a_valid),
      .a_rd        (a_rd),
      .a_data      (a_data),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_rd        (b_rd),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .rf_regwrite (rf_regwrite),
      .rf_rd       (rf_rd),
      .rf_wdata    (rf_wdata),
      .iss_valid   (iss_valid),
      .iss_rd      (iss_rd),
      .chk_rs1     (chk_rs1),
      .chk_rs2     (chk_rs2),
      .hazard      (hazard),
      .pending     (pending)
   );

   // Advance one clock; inputs are then driven and outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
      a_rd = 5'd7; a_data = 16'h1111; b_rd = 5'd9; b_data = 16'h2222;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got a=%b b=%b need 0 0", a_ready, b_ready);
         end
         step();
         total++;
         if (rf_regwrite !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 16'h0) begin
            bad++; $display("FAIL reset_rf: got we=%b rd=%0d d=%h need 0 0 0",
                            rf_regwrite, rf_rd, rf_wdata);
         end
         total++;
         if (pending !== 32'h0) begin
            bad++; $display("FAIL reset_pending: got %h need 0", pending);
         end
      end
      reset = 1'b1;
      #1;
      total++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         bad++; $display("FAIL reset_first_grant: got a=%b b=%b need 1 0", a_ready, b_ready);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      step();
      total++;
      if (rf_regwrite !== 1'b0) begin
         bad++; $display("FAIL reset_idle_we: got %b need 0", rf_regwrite);
      end
   endtask

   task automatic test_single_write();
      a_valid = 1'b1; a_rd = 5'd2; a_data = 16'h1234;
      #1;
      total++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         bad++; $display("FAIL single_grant: got a=%b b=%b need 1 0", a_ready, b_ready);
      end
      step();
      a_valid = 1'b0;
      total++;
      if (rf_regwrite !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 16'h1234) begin
         bad++; $display("FAIL single_write: got we=%b rd=%0d d=%h need 1 2 1234",
                         rf_regwrite, rf_rd, rf_wdata);
      end
      step();
      total++;
      if (rf_regwrite !== 1'b0 || rf_rd !== 5'd2 || rf_wdata !== 16'h1234) begin
         bad++; $display("FAIL single_hold: got we=%b rd=%0d d=%h need 0 2 1234",
                         rf_regwrite, rf_rd, rf_wdata);
      end
      total++;
      if (pending !== 32'h0) begin
         bad++; $display("FAIL single_pending: got %h need 0", pending);
      end
   endtask

   task automatic test_reg0();
      b_valid = 1'b1; b_rd = 5'd0; b_data = 16'hFFFF;
      iss_valid = 1'b1; iss_rd = 5'd0;
      #1;
      total++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
         bad++; $display("FAIL reg0_grant: got a=%b b=%b need 0 1", a_ready, b_ready);
      end
      step();
      b_valid = 1'b0; iss_valid = 1'b0;
      total++;
      if (rf_regwrite !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 16'hFFFF) begin
         bad++; $display("FAIL reg0_write: got we=%b rd=%0d d=%h need 0 0 ffff",
                         rf_regwrite, rf_rd, rf_wdata);
      end
      total++;
      if (pending !== 32'h0) begin
         bad++; $display("FAIL reg0_pending: got %h need 0", pending);
      end
   endtask

   task automatic test_contention();
      a_valid = 1'b1; a_rd = 5'd3; a_data = 16'h5678;
      b_valid = 1'b1; b_rd = 5'd4; b_data = 16'hABCD;
      #1;
      total++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         bad++; $display("FAIL cont_first: got a=%b b=%b need 1 0", a_ready, b_ready);
      end
      step();
      a_valid = 1'b0;
      #1;
      total++;
      if (rf_regwrite !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 16'h5678) begin
         bad++; $display("FAIL cont_write_a: got we=%b rd=%0d d=%h need 1 3 5678",
                         rf_regwrite, rf_rd, rf_wdata);
      end
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
         bad++; $display("FAIL cont_second: got a=%b b=%b need 0 1", a_ready, b_ready);
      end
      step();
      b_valid = 1'b0;
      total++;
      if (rf_regwrite !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 16'hABCD) begin
         bad++; $display("FAIL cont_write_b: got we=%b rd=%0d d=%h need 1 4 abcd",
                         rf_regwrite, rf_rd, rf_wdata);
      end
      step();
      total++;
      if (rf_regwrite !== 1'b0) begin
         bad++; $display("FAIL cont_no_dup: got we=%b need 0", rf_regwrite);
      end
   endtask

   task automatic test_back_to_back();
      int   na = 0;
      int   nb = 0;
      logic exp_a;
      logic [4:0] exp_rd;
      logic [15:0] exp_d;
      a_valid = 1'b1; b_valid = 1'b1;
      a_rd = 5'd10; a_data = 16'hA000;
      b_rd = 5'd20; b_data = 16'hB000;
      #1;
      for (int i = 0; i < 6; i++) begin
         exp_a = ((i % 2) == 0);
         total++;
         if (a_ready !== exp_a || b_ready !== !exp_a) begin
            bad++; $display("FAIL alt_grant[%0d]: got a=%b b=%b need %b %b",
                            i, a_ready, b_ready, exp_a, !exp_a);
         end
         exp_rd = exp_a ? 5'(10 + na) : 5'(20 + nb);
         exp_d  = exp_a ? 16'(16'hA000 + na) : 16'(16'hB000 + nb);
         step();
         total++;
         if (rf_regwrite !== 1'b1 || rf_rd !== exp_rd || rf_wdata !== exp_d) begin
            bad++; $display("FAIL alt_write[%0d]: got we=%b rd=%0d d=%h need 1 %0d %h",
                            i, rf_regwrite, rf_rd, rf_wdata, exp_rd, exp_d);
         end
         // Only the granted requester moves on to its next write.
         if (exp_a) begin
            na++; a_rd = 5'(10 + na); a_data = 16'(16'hA000 + na);
         end else begin
            nb++; b_rd = 5'(20 + nb); b_data = 16'(16'hB000 + nb);
         end
         #1;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      step();
   endtask

   task automatic test_scoreboard();
      chk_rs1 = 5'd5; chk_rs2 = 5'd0;
      iss_valid = 1'b1; iss_rd = 5'd5;
      #1;
      total++;
      if (hazard !== 1'b0) begin
         bad++; $display("FAIL sb_pre_issue: got hazard=%b need 0", hazard);
      end
      step();
      iss_valid = 1'b0;
      #1;
      total++;
      if (hazard !== 1'b1 || pending !== 32'h0000_0020) begin
         bad++; $display("FAIL sb_issued: got hazard=%b pend=%h need 1 00000020",
                         hazard, pending);
      end
      chk_rs1 = 5'd0; chk_rs2 = 5'd5;
      #1;
      total++;
      if (hazard !== 1'b1) begin
         bad++; $display("FAIL sb_rs2: got hazard=%b need 1", hazard);
      end
      chk_rs1 = 5'd5; chk_rs2 = 5'd6;
      a_valid = 1'b1; a_rd = 5'd5; a_data = 16'h0055;
      step();
      a_valid = 1'b0;
      #1;
      total++;
      if (rf_regwrite !== 1'b1 || rf_rd !== 5'd5 || hazard !== 1'b1) begin
         bad++; $display("FAIL sb_write_cycle: got we=%b rd=%0d hazard=%b need 1 5 1",
                         rf_regwrite, rf_rd, hazard);
      end
      step();
      total++;
      if (hazard !== 1'b0 || pending !== 32'h0) begin
         bad++; $display("FAIL sb_cleared: got hazard=%b pend=%h need 0 0", hazard, pending);
      end
      // Re-issue to r5 in the very cycle the older write to r5 retires.
      iss_valid = 1'b1; iss_rd = 5'd5;
      step();
      iss_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd5; a_data = 16'h0505;
      step();
      a_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd5;
      #1;
      total++;
      if (rf_regwrite !== 1'b1 || rf_rd !== 5'd5) begin
         bad++; $display("FAIL sb_race_write: got we=%b rd=%0d need 1 5", rf_regwrite, rf_rd);
      end
      step();
      iss_valid = 1'b0;
      #1;
      total++;
      if (pending !== 32'h0000_0020 || hazard !== 1'b1) begin
         bad++; $display("FAIL sb_set_wins: got pend=%h hazard=%b need 00000020 1",
                         pending, hazard);
      end
      // Write to a register that is not pending leaves the scoreboard alone.
      b_valid = 1'b1; b_rd = 5'd6; b_data = 16'h0606;
      step();
      b_valid = 1'b0;
      step();
      total++;
      if (pending !== 32'h0000_0020) begin
         bad++; $display("FAIL sb_unpending_write: got pend=%h need 00000020", pending);
      end
   endtask

   initial begin
      reset = 1'b0;
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
      iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
      step();
      test_reset();
      test_single_write();
      test_reg0();
      test_contention();
      test_back_to_back();
      test_scoreboard();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite/Rd/Write_data) between two writeback requesters: A = ALU writeback, B = load writeback.
- Round-robin arbitration with a valid/ready handshake.
- Registers the winning write toward the register file.
- Keeps a per-register pending scoreboard, so decode can stall on read-after-write hazards against Rs1/Rs2.

Parameters:
- DATA_W, 16, width of write data.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers (2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- a_valid  in  1  requester A has a write.
- a_rd  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- a_ready  out  1  A granted this cycle.
- b_valid  in  1  requester B has a write.
- b_rd  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- b_ready  out  1  B granted this cycle.
- rf_regwrite  out  1  to register_file RegWrite.
- rf_rd  out  ADDR_W  to register_file Rd.
- rf_wdata  out  DATA_W  to register_file Write_data.
- iss_valid  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  ADDR_W  destination of issued instruction.
- chk_rs1  in  ADDR_W  source 1 to hazard-check.
- chk_rs2  in  ADDR_W  source 2 to hazard-check.
- hazard  out  1  chk_rs1 or chk_rs2 is pending.
- pending  out  NREG  scoreboard bit vector.

Behaviour:
- Reset (reset==0 at posedge) clears all of:
  - rf_regwrite=0, rf_rd=0, rf_wdata=0.
  - pending=0.
  - Round-robin pointer last=B, so A wins the first tie.
- Reset overrides any in-flight grant or issue in that cycle.
- While reset is asserted, a_ready=b_ready=0.
- Arbitration is combinational from the valids and `last`:
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the one not equal to `last`.
  - Neither -> no grant.
- a_ready/b_ready equal the grant and never depend on ready. A transfer occurs when valid && ready in the same cycle.
- Requesters must hold rd/data stable while valid && !ready.
- `last` updates to the granted source only on a transfer.
- Latency is 1 cycle: a transfer in cycle N drives rf_regwrite/rf_rd/rf_wdata in cycle N+1.
- Writes to register 0:
  - Transfer is accepted (ready=1, consumed).
  - rf_regwrite stays 0 the next cycle.
  - rf_rd/rf_wdata still update.
- No transfer in cycle N -> rf_regwrite=0 in N+1; rf_rd/rf_wdata hold their previous values.
- Throughput is one write per cycle. With both requesters continuously valid, grants strictly alternate A,B,A,B.
- Scoreboard set: iss_valid && iss_rd!=0 sets pending[iss_rd] at the posedge.
- Scoreboard clear: in a cycle where rf_regwrite==1, pending[rf_rd] clears at that posedge. This is the same edge on which register_file captures the data.
- Simultaneous set and clear on the same register: set wins, because a newer producer is outstanding.
- pending[0] is always 0.
- hazard is combinational: (pending[chk_rs1] && chk_rs1!=0) || (pending[chk_rs2] && chk_rs2!=0). There is no bypass: hazard drops in the cycle after the write edge.
- A writeback to a register that is not pending is legal: it writes and pending stays 0.
- A second issue to an already pending register is legal: the bit stays 1 and clears on the first subsequent write to it. Only one outstanding producer per register is supported; decode stalls on a WAW hazard using `pending`.

Decomposition:
- Shared package: DATA_W/ADDR_W/NREG defaults and the requester-id encoding (SRC_A=0, SRC_B=1).
- One natural sub-module, rf_scoreboard: the pending vector, set/clear logic and hazard compare.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset: drive reset=0 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_regwrite=0, pending=0. Release reset; first cycle -> a_ready=1, b_ready=0.
- Single write: a_valid=1, a_rd=2, a_data=16'h1234 for 1 cycle -> next cycle rf_regwrite=1, rf_rd=2, rf_wdata=16'h1234; the following cycle rf_regwrite=0.
- Contention: A(rd=3, 16'h5678) and B(rd=4, 16'hABCD) both valid, held until granted -> grant A, then B. rf_rd sequence 3 then 4 on consecutive cycles; no lost or duplicated writes.
- Continuous both-valid for 6 cycles with changing rd -> grants alternate A,B,A,B,A,B.
- Register 0: b_valid=1, b_rd=0, b_data=16'hFFFF -> b_ready=1, next cycle rf_regwrite=0. iss_valid with iss_rd=0 -> pending stays 0.
- Scoreboard:
  - iss_valid, iss_rd=5, then chk_rs1=5 -> hazard=1.
  - A writes rd=5 -> hazard=1 through the rf_regwrite cycle, 0 the cycle after.
  - Repeat with iss_rd=5 in the same cycle rf_regwrite writes rd=5 -> pending[5] remains 1.
